// File: rtl/risc_pkg.sv
// Shared constants for the small RISC core: datapath widths and the opcode field
// that identifies HALT.
package risc_pkg;
    localparam int PC_W   = 8;
    localparam int INST_W = 32;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam logic [OPC_HI-OPC_LO:0] HALT_OP = 6'h3F;

    function automatic logic is_halt_opcode(input logic [OPC_HI-OPC_LO:0] opc);
        return opc == HALT_OP;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries with an async active-low reset
// and a synchronous clear that takes priority over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_if.sv
// Instruction fetch: issues ROM reads against a credit of queue slots, queues the
// returned words tagged with their PC, and latches a permanent halt on HALT.
module inst_fetch_if
    import risc_pkg::PC_W;
    import risc_pkg::OPC_HI;
    import risc_pkg::OPC_LO;
    import risc_pkg::is_halt_opcode;
#(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    output logic              freeze,
    output logic [PC_W-1:0]   mem_addr,
    output logic              mem_en,
    input  logic [INST_W-1:0] mem_data,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              dec_ready,
    output logic              halted
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: a head entry moves to decode in any cycle where inst_valid and
    // dec_ready are both 1; inst/inst_pc hold steady while inst_valid && !dec_ready.

    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           occ;
    logic                    inflight;
    logic [PC_W-1:0]         inflight_pc;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    halt_pop;
    logic                    fifo_clear;
    logic [PC_W+INST_W-1:0]  head;

    // The in-flight read already owns a slot, so issue never depends on dec_ready.
    assign occ        = fifo_count + CW'(inflight);
    assign issue      = (occ < CW'(DEPTH)) && !halted;
    assign freeze     = !issue;
    assign mem_en     = issue;
    assign mem_addr   = pc;

    assign push       = inflight && !halted;
    assign inst_valid = (fifo_count != '0) && !halted;
    assign pop        = inst_valid && dec_ready;
    assign inst       = head[INST_W-1:0];
    assign inst_pc    = head[PC_W+INST_W-1:INST_W];
    assign halt_pop   = pop && is_halt_opcode(inst[OPC_HI:OPC_LO]);
    assign fifo_clear = halt_pop || halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halted      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (halt_pop) begin
                halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .W    (PC_W + INST_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clear(fifo_clear),
        .push (push),
        .wdata({inflight_pc, mem_data}),
        .pop  (pop),
        .rdata(head),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_inst_fetch_if.sv
// Self-checking bench for inst_fetch_if: a ROM and instruction-pointer model drive
// the unit, and a queue model of issued-but-unconsumed fetches predicts its outputs.
module tb_inst_fetch_if;
    localparam int DEPTH  = 4;
    localparam int INST_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic        freeze;
    logic [7:0]  mem_addr;
    logic        mem_en;
    logic [31:0] mem_data;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_valid;
    logic        dec_ready;
    logic        halted;

    always #5 clk = ~clk;

    inst_fetch_if #(.DEPTH(DEPTH), .INST_W(INST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .freeze    (freeze),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_data  (mem_data),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_valid(inst_valid),
        .dec_ready (dec_ready),
        .halted    (halted)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc;

    logic [22:0] rom_salt;
    int          halt_pc;

    // Model: every fetch issued and not yet consumed, oldest first, with its issue cycle.
    logic [7:0]  mq_pc[$];
    int          mq_cyc[$];
    logic        m_halted;

    logic [51:0] obs_v;
    logic [51:0] exp_v;
    logic        obs_freeze;
    logic        obs_pop;
    logic [7:0]  obs_pc;
    int          obs_count;

    function automatic logic [31:0] rom(input logic [7:0] a);
        if (halt_pc == int'(a)) return 32'hFC00_0000;
        return {1'b0, rom_salt, a};
    endfunction

    task automatic do_reset(input logic [7:0] start_pc);
        rst       = 1'b0;
        dec_ready = 1'b0;
        pc        = start_pc;
        mem_data  = rom(start_pc + 8'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mq_pc.delete();
        mq_cyc.delete();
        m_halted = 1'b0;
        cyc      = 0;
    endtask

    // One clock cycle: sample outputs and model expectations at the negedge,
    // advance the model, then let the ROM and instruction pointer respond.
    task automatic step();
        logic        e_frz;
        logic        e_val;
        logic [7:0]  e_pc;
        logic [31:0] e_inst;
        logic        en_q;
        logic        frz_q;
        logic [7:0]  addr_q;
        logic [7:0]  p;
        logic [31:0] w;
        logic        halt_now;
        @(negedge clk);
        e_frz  = !((mq_pc.size() < DEPTH) && !m_halted);
        e_val  = !m_halted && (mq_pc.size() > 0) && (mq_cyc[0] <= cyc - 2);
        e_pc   = e_val ? mq_pc[0] : 8'h00;
        e_inst = e_val ? rom(mq_pc[0]) : 32'h0;
        exp_v  = {e_frz, !e_frz, pc, e_val, e_pc, e_inst, m_halted};
        obs_v  = {freeze, mem_en, mem_addr, inst_valid,
                  e_val ? inst_pc : 8'h00, e_val ? inst : 32'h0, halted};
        obs_freeze = freeze;
        obs_pop    = inst_valid && dec_ready;
        obs_pc     = inst_pc;
        obs_count  = int'(dut.fifo_count);
        en_q   = mem_en;
        frz_q  = freeze;
        addr_q = mem_addr;
        halt_now = 1'b0;
        if (e_val && dec_ready) begin
            p = mq_pc.pop_front();
            void'(mq_cyc.pop_front());
            w = rom(p);
            if (w[31:26] == 6'h3F) halt_now = 1'b1;
        end
        if (!e_frz) begin
            mq_pc.push_back(pc);
            mq_cyc.push_back(cyc);
        end
        if (halt_now) begin
            m_halted = 1'b1;
            mq_pc.delete();
            mq_cyc.delete();
        end
        @(posedge clk);
        #1;
        mem_data = en_q ? rom(addr_q) : $urandom;
        if (!frz_q) pc = pc + 8'd1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [51:0] got;
        logic [51:0] want;
        rom_salt = '0;
        halt_pc  = -1;
        do_reset(8'h10);
        @(negedge clk);
        got  = {freeze, mem_en, mem_addr, inst_valid, inst_pc, inst, halted};
        want = {1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 32'h0, 1'b0};
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL reset_outputs got=%h want=%h", got, want);
        end
        compared++;
        if (dut.fifo_count !== '0) begin
            mismatched++;
            $display("FAIL reset_count got=%0d want=0", dut.fifo_count);
        end
    endtask

    task automatic test_stream();
        int         first_valid;
        int         n_frz;
        int         n_pop;
        logic [7:0] next_pc;
        rom_salt = '0;
        halt_pc  = -1;
        do_reset(8'h00);
        dec_ready   = 1'b1;
        first_valid = -1;
        n_frz       = 0;
        n_pop       = 0;
        next_pc     = 8'h00;
        for (int i = 0; i < 12; i++) begin
            step();
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL stream cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (obs_pop && first_valid < 0) first_valid = i;
            if (obs_freeze) n_frz++;
            if (obs_pop) begin
                compared++;
                if (obs_pc !== next_pc) begin
                    mismatched++;
                    $display("FAIL stream_order got=%h want=%h", obs_pc, next_pc);
                end
                next_pc = obs_pc + 8'd1;
                n_pop++;
            end
        end
        compared++;
        if (first_valid != 2) begin
            mismatched++;
            $display("FAIL stream_latency got=%0d want=2", first_valid);
        end
        compared++;
        if (n_frz != 0 || n_pop != 10) begin
            mismatched++;
            $display("FAIL stream_rate freezes=%0d pops=%0d want 0 and 10", n_frz, n_pop);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] next_pc;
        int         n_pop;
        rom_salt = 23'($urandom);
        halt_pc  = -1;
        do_reset(8'h00);
        dec_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (i == 3 || i == 4) begin
                compared++;
                if (obs_freeze !== (i == 4)) begin
                    mismatched++;
                    $display("FAIL bp_freeze_rise cyc=%0d got=%b want=%b", i, obs_freeze, i == 4);
                end
            end
            if (i == 5) begin
                compared++;
                if (obs_count != DEPTH || obs_pc !== 8'h00) begin
                    mismatched++;
                    $display("FAIL bp_full count=%0d head=%h want %0d and 00", obs_count, obs_pc, DEPTH);
                end
            end
        end
        dec_ready = 1'b1;
        next_pc   = 8'h00;
        n_pop     = 0;
        for (int i = 6; i < 18; i++) begin
            step();
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL bp_drain cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (i == 6 || i == 7) begin
                compared++;
                if (obs_freeze !== (i == 6)) begin
                    mismatched++;
                    $display("FAIL bp_freeze_fall cyc=%0d got=%b want=%b", i, obs_freeze, i == 6);
                end
            end
            if (obs_pop) begin
                compared++;
                if (obs_pc !== next_pc) begin
                    mismatched++;
                    $display("FAIL bp_order got=%h want=%h", obs_pc, next_pc);
                end
                next_pc = obs_pc + 8'd1;
                n_pop++;
            end
        end
        compared++;
        if (n_pop < 8) begin
            mismatched++;
            $display("FAIL bp_resume pops=%0d want>=8", n_pop);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] next_pc;
        int         n_pop;
        rom_salt = 23'($urandom);
        halt_pc  = -1;
        do_reset(8'hFE);
        dec_ready = 1'b1;
        next_pc   = 8'hFE;
        n_pop     = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL wrap cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (obs_pop) begin
                compared++;
                if (obs_pc !== next_pc) begin
                    mismatched++;
                    $display("FAIL wrap_order got=%h want=%h", obs_pc, next_pc);
                end
                next_pc = next_pc + 8'd1;
                n_pop++;
            end
        end
        compared++;
        if (n_pop != 4 || next_pc !== 8'h02) begin
            mismatched++;
            $display("FAIL wrap_count pops=%0d next=%h want 4 and 02", n_pop, next_pc);
        end
    endtask

    task automatic test_halt();
        rom_salt = '0;
        halt_pc  = 5;
        do_reset(8'h00);
        dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i >= 12) dec_ready = 1'($urandom_range(0, 1));
            step();
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL halt cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (obs_pop) begin
                compared++;
                if (obs_pc > 8'd5) begin
                    mismatched++;
                    $display("FAIL halt_leak got=%h want<=05", obs_pc);
                end
            end
        end
        compared++;
        if ({halted, freeze, mem_en, inst_valid} !== 4'b1100) begin
            mismatched++;
            $display("FAIL halt_final got=%b want=1100", {halted, freeze, mem_en, inst_valid});
        end
        halt_pc = -1;
    endtask

    task automatic test_reset_mid();
        logic [51:0] got;
        logic [51:0] want;
        logic        seen;
        rom_salt = 23'($urandom);
        halt_pc  = -1;
        do_reset(8'h00);
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        compared++;
        if (dut.fifo_count !== 3'd3 || inst_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rmid_setup count=%0d valid=%b want 3 and 1", dut.fifo_count, inst_valid);
        end
        rst = 1'b0;
        #1;
        got  = {freeze, mem_en, mem_addr, inst_valid, inst_pc, inst, halted};
        want = {1'b0, 1'b1, pc, 1'b0, 8'h00, 32'h0, 1'b0};
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL rmid_async got=%h want=%h", got, want);
        end
        do_reset(8'h40);
        dec_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL rmid cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (obs_pop && !seen) begin
                seen = 1'b1;
                compared++;
                if (obs_pc !== 8'h40) begin
                    mismatched++;
                    $display("FAIL rmid_first got=%h want=40", obs_pc);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] next_pc;
        logic       started;
        rom_salt = 23'($urandom);
        halt_pc  = -1;
        do_reset(8'($urandom));
        started = 1'b0;
        next_pc = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            step();
            compared++;
            if (obs_v !== exp_v) begin
                mismatched++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            compared++;
            if (obs_count > DEPTH) begin
                mismatched++;
                $display("FAIL random_count cyc=%0d got=%0d want<=%0d", i, obs_count, DEPTH);
            end
            if (obs_pop) begin
                if (started) begin
                    compared++;
                    if (obs_pc !== next_pc) begin
                        mismatched++;
                        $display("FAIL random_order got=%h want=%h", obs_pc, next_pc);
                    end
                end
                started = 1'b1;
                next_pc = obs_pc + 8'd1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        pc        = 8'h00;
        dec_ready = 1'b0;
        mem_data  = '0;
        rom_salt  = '0;
        halt_pc   = -1;
        m_halted  = 1'b0;
        cyc       = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
